// File: rtl/dot_product_sequencer_if.sv
// Bundle of the sequencer's control, memory and ALU signals.
// The slave modport is the sequencer; the master modport is whatever surrounds it
// (top-level control, memory and ALU).
interface dot_product_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic [7:0]        len;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] stride_b;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_out;
  logic              alu_z;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              result_zero;

  modport master (
    output start, len, base_a, base_b, stride_b, mem_rd_data, alu_out, alu_z,
    input  mem_addr, mem_rd_en, alu_in1, alu_in2, alu_op, busy, done, result, result_zero
  );

  modport slave (
    input  start, len, base_a, base_b, stride_b, mem_rd_data, alu_out, alu_z,
    output mem_addr, mem_rd_en, alu_in1, alu_in2, alu_op, busy, done, result, result_zero
  );
endinterface

// File: rtl/dot_product_sequencer.sv
// Sequences a shared 16-bit ALU to compute sum(A[i]*B[i]) over len elements.
// Each element takes five cycles: fetch A, fetch B, latch B, multiply, accumulate.
// Operands come from a synchronous-read memory; the accumulate also goes through the ALU.
module dot_product_sequencer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  dot_product_sequencer_if.slave bus
);

  localparam logic [2:0] OpAdd  = 3'd0;
  localparam logic [2:0] OpMul  = 3'd2;
  localparam logic [2:0] OpPass = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StFetchA,
    StFetchB,
    StLatchB,
    StMul,
    StAcc,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        len_q, cnt_q;
  logic [ADDR_W-1:0] stride_q, ptr_a_q, ptr_b_q;
  logic [DATA_W-1:0] op_a_q, op_b_q, prod_q, acc_q, result_q;
  logic              result_zero_q, busy_q, done_q;
  logic              last;

  // len is never 0 once past IDLE, so len-1 cannot underflow here
  assign last = (cnt_q == len_q - 8'd1);

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = (bus.len == 8'd0) ? StDone : StFetchA;
      end
      StFetchA: state_d = StFetchB;
      StFetchB: state_d = StLatchB;
      StLatchB: state_d = StMul;
      StMul:    state_d = StAcc;
      StAcc:    state_d = last ? StDone : StFetchA;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Memory and ALU drive, decoded from state; idle ALU setting is pass-in2 of zero
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_rd_en = 1'b0;
    bus.alu_in1   = '0;
    bus.alu_in2   = '0;
    bus.alu_op    = OpPass;
    unique case (state_q)
      StFetchA: begin
        bus.mem_addr  = ptr_a_q;
        bus.mem_rd_en = 1'b1;
      end
      StFetchB: begin
        bus.mem_addr  = ptr_b_q;
        bus.mem_rd_en = 1'b1;
      end
      StMul: begin
        bus.alu_op  = OpMul;
        bus.alu_in1 = op_a_q;
        bus.alu_in2 = op_b_q;
      end
      StAcc: begin
        bus.alu_op  = OpAdd;
        bus.alu_in1 = acc_q;
        bus.alu_in2 = prod_q;
      end
      default: ;
    endcase
  end

  // State, datapath registers and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      len_q         <= '0;
      cnt_q         <= '0;
      stride_q      <= '0;
      ptr_a_q       <= '0;
      ptr_b_q       <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      prod_q        <= '0;
      acc_q         <= '0;
      result_q      <= '0;
      result_zero_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            len_q    <= bus.len;
            stride_q <= bus.stride_b;
            ptr_a_q  <= bus.base_a;
            ptr_b_q  <= bus.base_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            // Empty product: result is defined as zero
            if (bus.len == 8'd0) begin
              result_q      <= '0;
              result_zero_q <= 1'b1;
            end
          end
        end
        StFetchB: begin
          op_a_q  <= bus.mem_rd_data;
          ptr_a_q <= ptr_a_q + 1'b1;
          ptr_b_q <= ptr_b_q + stride_q;
        end
        StLatchB: op_b_q <= bus.mem_rd_data;
        StMul:    prod_q <= bus.alu_out;
        StAcc: begin
          acc_q <= bus.alu_out;
          cnt_q <= cnt_q + 8'd1;
          if (last) begin
            result_q      <= bus.alu_out;
            result_zero_q <= bus.alu_z;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.result_zero = result_zero_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Bench for dot_product_sequencer: models the memory and ALU around it and checks
// results, read address order and done timing against a plain arithmetic reference.
module tb_dot_product_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_product_sequencer_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  dot_product_sequencer #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] mem [256];
  int n_checks = 0;
  int n_fail = 0;

  // Observations from the most recent run
  int          obs_done_cyc, obs_done_cnt, obs_busy_cnt;
  logic [15:0] obs_res;
  logic        obs_rz;
  int          obs_addrs[$];
  int          exp_addrs[$];

  // Environment: synchronous-read memory and the combinational ALU
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];

  always_comb begin
    bus.alu_out = 16'h0000;
    case (bus.alu_op)
      3'd0:    bus.alu_out = bus.alu_in1 + bus.alu_in2;
      3'd2:    bus.alu_out = bus.alu_in1 * bus.alu_in2;
      3'd4:    bus.alu_out = bus.alu_in2;
      default: bus.alu_out = 16'h0000;
    endcase
    bus.alu_z = (bus.alu_out == 16'h0000);
  end

  function automatic int dot_ref(input int l, input int ba, input int bb, input int sb);
    int unsigned s = 0;
    for (int i = 0; i < l; i++) begin
      int unsigned a = mem[(ba + i) & 255];
      int unsigned b = mem[(bb + i * sb) & 255];
      s = (s + ((a * b) & 32'hFFFF)) & 32'hFFFF;
    end
    return int'(s);
  endfunction

  function automatic void build_addrs(input int l, input int ba, input int bb, input int sb);
    exp_addrs.delete();
    for (int i = 0; i < l; i++) begin
      exp_addrs.push_back((ba + i) & 255);
      exp_addrs.push_back((bb + i * sb) & 255);
    end
  endfunction

  function automatic bit addrs_match();
    if (exp_addrs.size() != obs_addrs.size()) return 1'b0;
    foreach (exp_addrs[k]) if (exp_addrs[k] != obs_addrs[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Starts a run in cycle 0 and observes cycles 1..budget; inject>0 pulses a stray start
  task automatic exec(input int l, input int ba, input int bb, input int sb, input int inject);
    int budget = 5 * l + 3;
    obs_addrs.delete();
    obs_done_cyc = -1;
    obs_done_cnt = 0;
    obs_busy_cnt = 0;
    obs_res = 16'hxxxx;
    obs_rz = 1'bx;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len = 8'(l);
    bus.base_a = 8'(ba);
    bus.base_b = 8'(bb);
    bus.stride_b = 8'(sb);
    @(negedge clk);
    for (int c = 1; c <= budget; c++) begin
      if (bus.busy) obs_busy_cnt++;
      if (bus.mem_rd_en) obs_addrs.push_back(int'(bus.mem_addr));
      if (bus.done) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = c;
          obs_res = bus.result;
          obs_rz = bus.result_zero;
        end
      end
      // Scrambled inputs must not disturb the run in progress
      bus.start = (c == inject);
      bus.len = (c == inject) ? 8'd1 : 8'($urandom);
      bus.base_a = 8'($urandom);
      bus.base_b = 8'($urandom);
      bus.stride_b = 8'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({bus.busy, bus.done, bus.result_zero, bus.mem_rd_en} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done/rz/rd_en=%b required 0000",
               {bus.busy, bus.done, bus.result_zero, bus.mem_rd_en});
    end
    n_checks++;
    if ({bus.mem_addr, bus.alu_in1, bus.alu_in2, bus.result} !== 56'h0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%h in1=%h in2=%h result=%h required all 0",
               bus.mem_addr, bus.alu_in1, bus.alu_in2, bus.result);
    end
    n_checks++;
    if (bus.alu_op !== 3'd4) begin
      n_fail++;
      $display("FAIL reset_alu_op: got %0d required 4", bus.alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.alu_op !== 3'd4) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b alu_op=%0d required 0/4", bus.busy, bus.alu_op);
    end
  endtask

  task automatic test_basic();
    mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3;
    mem[8'h20] = 16'd4; mem[8'h21] = 16'd5; mem[8'h22] = 16'd6;
    exec(3, 8'h10, 8'h20, 1, 0);
    exp_addrs = '{16, 32, 17, 33, 18, 34};
    n_checks++;
    if (obs_res !== 16'd32 || obs_rz !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got %0d rz=%b required 32 rz=0", obs_res, obs_rz);
    end
    n_checks++;
    if (obs_done_cyc != 16 || obs_done_cnt != 1) begin
      n_fail++;
      $display("FAIL basic_done: cycle %0d count %0d required cycle 16 count 1",
               obs_done_cyc, obs_done_cnt);
    end
    n_checks++;
    if (obs_busy_cnt != 16) begin
      n_fail++;
      $display("FAIL basic_busy: %0d busy cycles required 16", obs_busy_cnt);
    end
    n_checks++;
    if (!addrs_match()) begin
      n_fail++;
      $display("FAIL basic_addrs: %0d reads, got %p required %p",
               obs_addrs.size(), obs_addrs, exp_addrs);
    end
  endtask

  task automatic test_stride();
    mem[8'h50] = 16'd7; mem[8'h51] = 16'd9;
    mem[8'h40] = 16'd2; mem[8'h44] = 16'd3; mem[8'h41] = 16'd100;
    exec(2, 8'h50, 8'h40, 4, 0);
    exp_addrs = '{80, 64, 81, 68};
    n_checks++;
    if (obs_res !== 16'd41) begin
      n_fail++;
      $display("FAIL stride_result: got %0d required 41", obs_res);
    end
    n_checks++;
    if (!addrs_match()) begin
      n_fail++;
      $display("FAIL stride_addrs: got %p required %p", obs_addrs, exp_addrs);
    end
  endtask

  task automatic test_zero_len();
    exec(0, 8'h10, 8'h20, 1, 0);
    n_checks++;
    if (obs_done_cyc != 1 || obs_done_cnt != 1 || obs_busy_cnt != 1) begin
      n_fail++;
      $display("FAIL zero_done: cycle %0d count %0d busy %0d required 1/1/1",
               obs_done_cyc, obs_done_cnt, obs_busy_cnt);
    end
    n_checks++;
    if (obs_res !== 16'd0 || obs_rz !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_result: got %0d rz=%b required 0 rz=1", obs_res, obs_rz);
    end
    n_checks++;
    if (obs_addrs.size() != 0) begin
      n_fail++;
      $display("FAIL zero_reads: %0d reads required 0", obs_addrs.size());
    end
  endtask

  task automatic test_wrap();
    mem[8'h30] = 16'd300; mem[8'h31] = 16'd300;
    exec(1, 8'h30, 8'h31, 1, 0);
    n_checks++;
    if (obs_res !== 16'd24464 || obs_done_cyc != 6) begin
      n_fail++;
      $display("FAIL wrap_arith: got %0d at cycle %0d required 24464 at cycle 6",
               obs_res, obs_done_cyc);
    end
    mem[8'hFE] = 16'd1; mem[8'hFF] = 16'd2; mem[8'h00] = 16'd3;
    mem[8'h60] = 16'd10; mem[8'h61] = 16'd20; mem[8'h62] = 16'd30;
    exec(3, 8'hFE, 8'h60, 1, 0);
    exp_addrs = '{254, 96, 255, 97, 0, 98};
    n_checks++;
    if (!addrs_match() || obs_res !== 16'd140) begin
      n_fail++;
      $display("FAIL wrap_addr: result %0d reads %p required 140 reads %p",
               obs_res, obs_addrs, exp_addrs);
    end
    mem[8'h32] = 16'd256; mem[8'h33] = 16'd256;
    exec(1, 8'h32, 8'h33, 1, 0);
    n_checks++;
    if (obs_res !== 16'd0 || obs_rz !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_zero: got %0d rz=%b required 0 rz=1", obs_res, obs_rz);
    end
  endtask

  task automatic test_busy_start();
    mem[8'h10] = 16'd1; mem[8'h11] = 16'd2; mem[8'h12] = 16'd3;
    mem[8'h20] = 16'd4; mem[8'h21] = 16'd5; mem[8'h22] = 16'd6;
    exec(3, 8'h10, 8'h20, 1, 5);
    n_checks++;
    if (obs_res !== 16'd32 || obs_done_cyc != 16 || obs_done_cnt != 1) begin
      n_fail++;
      $display("FAIL busy_start: result %0d cycle %0d dones %0d required 32/16/1",
               obs_res, obs_done_cyc, obs_done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len = 8'd3;
    bus.base_a = 8'h10;
    bus.base_b = 8'h20;
    bus.stride_b = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c < 7; c++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr, bus.alu_op, bus.result} !==
        {3'b000, 8'h00, 3'd4, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_mid_async: busy=%b done=%b rd_en=%b addr=%h op=%0d result=%0d",
               bus.busy, bus.done, bus.mem_rd_en, bus.mem_addr, bus.alu_op, bus.result);
    end
    for (int c = 0; c < 12; c++) begin
      if (c == 3) rst_n = 1'b1;
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_mid_done: %0d done pulses required 0", dones);
    end
    mem[8'h70] = 16'd5; mem[8'h71] = 16'd6;
    exec(1, 8'h70, 8'h71, 1, 0);
    n_checks++;
    if (obs_res !== 16'd30 || obs_done_cyc != 6) begin
      n_fail++;
      $display("FAIL reset_mid_rerun: got %0d at cycle %0d required 30 at cycle 6",
               obs_res, obs_done_cyc);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int l = (it == 0) ? 255 : int'($urandom_range(1, 12));
      int ba = int'($urandom_range(0, 255));
      int bb = int'($urandom_range(0, 255));
      int sb = int'($urandom_range(0, 255));
      int er;
      for (int i = 0; i < 256; i++) mem[i] = (it % 4 == 3) ? 16'($urandom_range(0, 3)) :
                                                              16'($urandom);
      er = dot_ref(l, ba, bb, sb);
      build_addrs(l, ba, bb, sb);
      exec(l, ba, bb, sb, 0);
      n_checks++;
      if (obs_res !== 16'(er) || obs_rz !== (er == 0)) begin
        n_fail++;
        $display("FAIL random_result[%0d]: len %0d got %0d rz=%b required %0d rz=%b",
                 it, l, obs_res, obs_rz, er, er == 0);
      end
      n_checks++;
      if (obs_done_cyc != 1 + 5 * l || obs_done_cnt != 1) begin
        n_fail++;
        $display("FAIL random_done[%0d]: cycle %0d count %0d required cycle %0d count 1",
                 it, obs_done_cyc, obs_done_cnt, 1 + 5 * l);
      end
      n_checks++;
      if (!addrs_match()) begin
        n_fail++;
        $display("FAIL random_addrs[%0d]: %0d reads required %0d, order or values differ",
                 it, obs_addrs.size(), exp_addrs.size());
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.len = 8'd0;
    bus.base_a = 8'd0;
    bus.base_b = 8'd0;
    bus.stride_b = 8'd0;
    bus.mem_rd_data = 16'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    test_reset();
    test_basic();
    test_stride();
    test_zero_len();
    test_wrap();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
